// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial bit-pattern detector for framing / sync-word search. A PAT_W-bit
//   pattern (reset value PATTERN, reloadable at run time) is compared against
//   the most recent valid bits. The first bit received is the pattern MSB.
//   Detection can be overlapping or non-overlapping. The block provides a Mealy
//   match, a registered match and a saturating match counter.
//
//   Optional feature macro: SEQ_MATCH_CNT_EN
//     defined   -> match_count / cnt_clr implemented
//     undefined -> no counter logic, match_count tied to 0, cnt_clr ignored
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   qualifies `in` this cycle
//   in           in   serial data bit
//   overlap      in   1 = overlapping, 0 = non-overlapping detection
//   pat_we       in   load pattern_in (restarts detection)
//   pattern_in   in   [PAT_W-1:0] new pattern
//   cnt_clr      in   synchronous clear of match_count
//   match        out  combinational match on the completing bit
//   match_q      out  match delayed by one cycle
//   armed        out  FSM state: 1 when PAT_W-1 history bits are held
//   match_count  out  [CNT_W-1:0] saturating match count
//
// Handshake: a bit is consumed on every rising clk edge where in_valid=1 and
// pat_we=0. There is no back-pressure; the detector always accepts.

module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_we,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic             match_q,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam int FILL_W = $clog2(PAT_W);
  // fill value at which the history is full
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t             state;
  logic [PAT_W-2:0]   hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_W-1:0]   pat_reg;
  logic [PAT_W-1:0]   window;

  // Candidate word: held history followed by the incoming bit (newest = LSB).
  assign window = {hist, in};

  // A pattern load in the same cycle drops the bit, so it can never match.
  assign match = in_valid & ~pat_we & (state == ARMED) & (window == pat_reg);

  // The state register drives armed directly, which also exposes the FSM state.
  assign armed = (state == ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      pat_reg <= PATTERN;
      match_q <= 1'b0;
    end else begin
      match_q <= match;
      if (pat_we) begin
        pat_reg <= pattern_in;
        hist    <= '0;
        fill    <= '0;
        state   <= FILL;
      end else if (in_valid) begin
        case (state)
          FILL: begin
            hist <= window[PAT_W-2:0];
            fill <= fill + FILL_W'(1);
            if (fill == FILL_LAST - FILL_W'(1)) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (match && !overlap) begin
              // Non-overlapping: the completing bit is not reused.
              hist  <= '0;
              fill  <= '0;
              state <= FILL;
            end else begin
              hist <= window[PAT_W-2:0];
            end
          end
          default: begin
            state <= FILL;
          end
        endcase
      end
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  // Clear wins over a simultaneous increment. The count holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= '0;
    end else if (match && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
//   Bench for seq_detector_param (PAT_W=4, PATTERN=1101, CNT_W=2).
//   The bench has three parts:
//     - A table of directed vectors taken from the test plan.
//     - A hand-written mid-cycle reset sequence.
//     - Randomized traffic checked against a queue-based reference model.
//   The model keeps the valid bits seen since the last restart. A match means
//   the last PAT_W bits equal the pattern.

module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             overlap = 1'b1;
  logic             pat_we = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic             cnt_clr = 1'b0;
  logic             match;
  logic             match_q;
  logic             armed;
  logic [CNT_W-1:0] match_count;

  seq_detector_param #(
    .PAT_W   (PAT_W),
    .PATTERN (4'b1101),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in          (in_bit),
    .overlap     (overlap),
    .pat_we      (pat_we),
    .pattern_in  (pattern_in),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_q     (match_q),
    .armed       (armed),
    .match_count (match_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit               hq[$];      // valid bits since restart, capped to PAT_W-1
  logic [PAT_W-1:0] mpat;
  int               mcnt;
  bit               m_match;    // expected match for the current cycle
  bit               m_match_q;

  function automatic void model_reset();
    hq.delete();
    mpat      = 4'b1101;
    mcnt      = 0;
    m_match   = 1'b0;
    m_match_q = 1'b0;
  endfunction

  function automatic bit model_match(input bit v, input bit b, input bit we);
    int w;
    if (!v || we || hq.size() != PAT_W - 1) return 1'b0;
    w = 0;
    foreach (hq[i]) w = (w << 1) | int'(hq[i]);
    w = (w << 1) | int'(b);
    return w == int'(mpat);
  endfunction

  function automatic void model_clock(input bit v, input bit b, input bit ov,
                                      input bit we, input logic [PAT_W-1:0] p,
                                      input bit clr);
    m_match_q = m_match;
    if (clr) mcnt = 0;
    else if (m_match && mcnt < CNT_MAX) mcnt++;
    if (we) begin
      mpat = p;
      hq.delete();
    end else if (v) begin
      if (m_match && !ov) begin
        hq.delete();
      end else begin
        hq.push_back(b);
        if (hq.size() > PAT_W - 1) void'(hq.pop_front());
      end
    end
  endfunction

  function automatic int exp_cnt(input int c);
    return CNT_EN ? c : 0;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, check the Mealy output mid-cycle, then
  // advance the model at posedge and check the registered outputs.
  task automatic drive(input bit v, input bit b, input bit ov, input bit we,
                       input logic [PAT_W-1:0] p, input bit clr);
    @(negedge clk);
    in_valid   = v;
    in_bit     = b;
    overlap    = ov;
    pat_we     = we;
    pattern_in = p;
    cnt_clr    = clr;
    #2;
    m_match = model_match(v, b, we);
    check("model_match", int'(match), int'(m_match));
    @(posedge clk);
    model_clock(v, b, ov, we, p, clr);
    #1;
    check("model_match_q", int'(match_q), int'(m_match_q));
    check("model_armed", int'(armed), int'(hq.size() == PAT_W - 1));
    check("model_count", int'(match_count), exp_cnt(mcnt));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    pat_we   = 1'b0;
    cnt_clr  = 1'b0;
    #1;
    check("rst_match", int'(match), 0);
    check("rst_match_q", int'(match_q), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_count", int'(match_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit               rst_before;
    bit               v;
    bit               b;
    bit               ov;
    bit               we;
    logic [PAT_W-1:0] p;
    bit               clr;
    bit               e_match;
    bit               e_armed;
    int               e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit v, input bit b, input bit ov,
                              input bit we, input logic [PAT_W-1:0] p, input bit clr,
                              input bit em, input bit ea, input int ec);
    vec_t t;
    t = '{rst_before: r, v: v, b: b, ov: ov, we: we, p: p, clr: clr,
          e_match: em, e_armed: ea, e_cnt: ec};
    vecs.push_back(t);
  endfunction

  initial begin
    bit obs_match;
    bit rv, rb, rwe, rclr;
    logic [PAT_W-1:0] rp;

    model_reset();
    rst = 1'b1;
    #12;
    check("reset_match", int'(match), 0);
    check("reset_armed", int'(armed), 0);
    check("reset_count", int'(match_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Overlapping, 1101101: matches on bits 4 and 7.
    add(1,1,1,1,0,4'h0,0, 0,0,0); add(0,1,1,1,0,4'h0,0, 0,0,0);
    add(0,1,0,1,0,4'h0,0, 0,1,0); add(0,1,1,1,0,4'h0,0, 1,1,1);
    add(0,1,1,1,0,4'h0,0, 0,1,1); add(0,1,0,1,0,4'h0,0, 0,1,1);
    add(0,1,1,1,0,4'h0,0, 1,1,2);
    // Non-overlapping, same stream: a single match, then refill.
    add(1,1,1,0,0,4'h0,0, 0,0,0); add(0,1,1,0,0,4'h0,0, 0,0,0);
    add(0,1,0,0,0,4'h0,0, 0,1,0); add(0,1,1,0,0,4'h0,0, 1,0,1);
    add(0,1,1,0,0,4'h0,0, 0,0,1); add(0,1,0,0,0,4'h0,0, 0,0,1);
    add(0,1,1,0,0,4'h0,0, 0,1,1);
    // in_valid gaps: history is held, and idle bits are ignored.
    add(1,1,1,1,0,4'h0,0, 0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,1,0,4'h0,0, 0,0,0);
    add(0,1,1,1,0,4'h0,0, 0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,1,1,0,4'h0,0, 0,0,0);
    add(0,1,0,1,0,4'h0,0, 0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,1,1,0,4'h0,0, 0,1,0);
    add(0,1,1,1,0,4'h0,0, 1,1,1);
    // Pattern load with a simultaneous valid bit, then 0110. Old 1101 is dead.
    add(1,1,1,1,1,4'b0110,0, 0,0,0); add(0,1,0,1,0,4'h0,0, 0,0,0);
    add(0,1,1,1,0,4'h0,0, 0,0,0);    add(0,1,1,1,0,4'h0,0, 0,1,0);
    add(0,1,0,1,0,4'h0,0, 1,1,1);    add(0,1,1,1,0,4'h0,0, 0,1,1);
    // Saturation at CNT_W=2, then clear together with a match.
    add(1,1,1,1,0,4'h0,0, 0,0,0); add(0,1,1,1,0,4'h0,0, 0,0,0);
    add(0,1,0,1,0,4'h0,0, 0,1,0); add(0,1,1,1,0,4'h0,0, 1,1,1);
    for (int k = 2; k <= 5; k++) begin
      add(0,1,1,1,0,4'h0,0, 0,1,k-1 > 3 ? 3 : k-1);
      add(0,1,0,1,0,4'h0,0, 0,1,k-1 > 3 ? 3 : k-1);
      add(0,1,1,1,0,4'h0,0, 1,1,k > 3 ? 3 : k);
    end
    add(0,1,1,1,0,4'h0,0, 0,1,3); add(0,1,0,1,0,4'h0,0, 0,1,3);
    add(0,1,1,1,0,4'h0,1, 1,1,0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) reset_dut();
      drive(vecs[i].v, vecs[i].b, vecs[i].ov, vecs[i].we, vecs[i].p, vecs[i].clr);
      obs_match = match_q;  // match from the driven cycle, now registered
      check($sformatf("vec%0d_match", i), int'(obs_match), int'(vecs[i].e_match));
      check($sformatf("vec%0d_armed", i), int'(armed), int'(vecs[i].e_armed));
      check($sformatf("vec%0d_count", i), int'(match_count), exp_cnt(vecs[i].e_cnt));
    end

    // Reset asserted mid-cycle, while a completing bit is presented.
    reset_dut();
    drive(1,1,1,0,4'h0,0); drive(1,1,1,0,4'h0,0);
    drive(1,0,1,0,4'h0,0); drive(1,1,1,0,4'h0,0);   // match, count=1
    drive(1,1,1,0,4'h0,0); drive(1,0,1,0,4'h0,0);   // hist=110
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    #2;
    check("pre_rst_match", int'(match), 1);
    rst = 1'b1;
    #1;
    check("midrst_match", int'(match), 0);
    check("midrst_match_q", int'(match_q), 0);
    check("midrst_armed", int'(armed), 0);
    check("midrst_count", int'(match_count), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1,1,1,0,4'h0,0);
    check("post_rst_no_match", int'(match_q), 0);
    check("post_rst_armed", int'(armed), 0);

    // Randomized traffic against the model.
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      rv   = ($urandom_range(0, 9) < 7);
      rb   = $urandom_range(0, 1) != 0;
      rwe  = ($urandom_range(0, 59) == 0);
      rclr = ($urandom_range(0, 49) == 0);
      rp   = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
      if ($urandom_range(0, 15) == 0) overlap = ~overlap;
      drive(rv, rb, overlap, rwe, rp, rclr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
